// File: rtl/bus_rx_fifo_if.sv
// Handshake bundle between the bus output port, the receive FIFO and its local consumer.
// master drives push/D_push/pop; slave is the FIFO that owns the status outputs.
interface bus_rx_fifo_if #(
   parameter int pckg_sz = 16,
   parameter int depth   = 8,
   parameter int cnt_w   = 16
);
   localparam int cw = $clog2(depth) + 1;

   logic               push;
   logic [pckg_sz-1:0] D_push;
   logic               pop;
   logic [pckg_sz-1:0] D_pop;
   logic               pndng;
   logic               full;
   logic [cw-1:0]      count;
   logic               overflow;
   logic               underflow;
   logic [cnt_w-1:0]   rx_cnt;
   logic [cnt_w-1:0]   drop_cnt;

   modport master (
      output push, D_push, pop,
      input  D_pop, pndng, full, count, overflow, underflow, rx_cnt, drop_cnt
   );

   modport slave (
      input  push, D_push, pop,
      output D_pop, pndng, full, count, overflow, underflow, rx_cnt, drop_cnt
   );
endinterface

// File: rtl/bus_rx_fifo.sv
// Receive-side terminal buffer: filters bus packets by destination id, stores hits in a
// show-ahead FIFO and keeps sticky error flags plus saturating accept/drop statistics.
module bus_rx_fifo #(
   parameter int         pckg_sz   = 16,
   parameter int         depth     = 8,
   parameter logic [7:0] id        = 8'h00,
   parameter logic [7:0] broadcast = 8'hFF,
   parameter int         cnt_w     = 16
) (
   input logic         clk,
   input logic         reset,
   bus_rx_fifo_if.slave bif
);
   localparam int aw = $clog2(depth);
   localparam int cw = aw + 1;

   logic [pckg_sz-1:0] mem [depth];
   logic [aw-1:0]      wr_ptr;
   logic [aw-1:0]      rd_ptr;
   logic [cw-1:0]      count_q;
   logic               overflow_q;
   logic               underflow_q;
   logic [cnt_w-1:0]   rx_q;
   logic [cnt_w-1:0]   drop_q;

   logic [7:0] dst;
   logic       hit;
   logic       is_empty;
   logic       is_full;
   logic       rd_accept;
   logic       wr_accept;
   logic       ovf_ev;
   logic       drop;

   // A pop on a full FIFO frees the slot the same edge, so a concurrent hit is kept.
   always_comb begin
      dst       = bif.D_push[pckg_sz-1 -: 8];
      hit       = (dst == id) || (dst == broadcast);
      is_empty  = (count_q == '0);
      is_full   = (count_q == cw'(depth));
      rd_accept = bif.pop && !is_empty;
      wr_accept = bif.push && hit && (!is_full || rd_accept);
      ovf_ev    = bif.push && hit && is_full && !bif.pop;
      drop      = bif.push && !wr_accept;
   end

   always_ff @(posedge clk) begin
      if (wr_accept) mem[wr_ptr] <= bif.D_push;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rx_q        <= '0;
         drop_q      <= '0;
      end else begin
         if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
         if (rd_accept) rd_ptr <= rd_ptr + 1'b1;
         count_q <= count_q + cw'(wr_accept) - cw'(rd_accept);
         if (ovf_ev) overflow_q <= 1'b1;
         if (bif.pop && is_empty) underflow_q <= 1'b1;
         if (wr_accept && (rx_q != '1)) rx_q <= rx_q + 1'b1;
         if (drop && (drop_q != '1)) drop_q <= drop_q + 1'b1;
      end
   end

   assign bif.D_pop     = is_empty ? '0 : mem[rd_ptr];
   assign bif.pndng     = !is_empty;
   assign bif.full      = is_full;
   assign bif.count     = count_q;
   assign bif.overflow  = overflow_q;
   assign bif.underflow = underflow_q;
   assign bif.rx_cnt    = rx_q;
   assign bif.drop_cnt  = drop_q;
endmodule

// File: tb/tb_bus_rx_fifo.sv
// Scoreboard bench for bus_rx_fifo (id=2): accepted pushes queue expected data, pops compare it.
module tb_bus_rx_fifo;
   localparam int pckg_sz = 16;
   localparam int depth   = 8;
   localparam int cnt_w   = 16;

   logic clk = 1'b0;
   logic reset;

   bus_rx_fifo_if #(.pckg_sz(pckg_sz), .depth(depth), .cnt_w(cnt_w)) bif ();

   bus_rx_fifo #(
      .pckg_sz(pckg_sz), .depth(depth), .id(8'h02), .broadcast(8'hFF), .cnt_w(cnt_w)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bif  (bif)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   logic [pckg_sz-1:0] sb_q [$];
   int m_rx, m_drop;
   bit m_ovf, m_unf;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      sb_q.delete();
      m_rx = 0; m_drop = 0; m_ovf = 0; m_unf = 0;
   endtask

   task automatic check_state(input string tag);
      check_val({tag, ".count"}, 32'(bif.count), 32'(sb_q.size()));
      check_val({tag, ".pndng"}, 32'(bif.pndng), 32'(sb_q.size() != 0));
      check_val({tag, ".full"}, 32'(bif.full), 32'(sb_q.size() == depth));
      check_val({tag, ".dpop"}, 32'(bif.D_pop), (sb_q.size() != 0) ? 32'(sb_q[0]) : 32'h0);
      check_val({tag, ".ovf"}, 32'(bif.overflow), 32'(m_ovf));
      check_val({tag, ".unf"}, 32'(bif.underflow), 32'(m_unf));
      check_val({tag, ".rx"}, 32'(bif.rx_cnt), 32'(m_rx));
      check_val({tag, ".drop"}, 32'(bif.drop_cnt), 32'(m_drop));
   endtask

   // Drive one cycle; called #1 after a rising edge, returns #1 after the next one.
   task automatic step(input bit p, input logic [pckg_sz-1:0] d, input bit po);
      bit hit, full_m, rd, wr;
      bif.push   = p;
      bif.D_push = d;
      bif.pop    = po;
      #3;
      if (po && sb_q.size() != 0) check_val("pop_data", 32'(bif.D_pop), 32'(sb_q[0]));
      hit    = (d[15:8] == 8'h02) || (d[15:8] == 8'hFF);
      full_m = (sb_q.size() == depth);
      rd     = po && (sb_q.size() != 0);
      wr     = p && hit && (!full_m || rd);
      if (po && !rd) m_unf = 1;
      if (p && hit && full_m && !po) m_ovf = 1;
      if (p && !wr && m_drop < 65535) m_drop++;
      if (wr && m_rx < 65535) m_rx++;
      if (rd) void'(sb_q.pop_front());
      if (wr) sb_q.push_back(d);
      @(posedge clk);
      #1;
      bif.push = 1'b0;
      bif.pop  = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b0;
      bif.push   = 1'b0;
      bif.pop    = 1'b0;
      bif.D_push = '0;
      model_reset();
      #12;
      do_reset();
      check_state("reset");

      // Three hits in, three out in order.
      for (int i = 1; i <= 3; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0);
      check_val("three_count", 32'(bif.count), 32'd3);
      for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
      check_state("drain3");
      check_val("three_rx", 32'(bif.rx_cnt), 32'd3);

      // Misaddressed packet dropped, broadcast kept.
      step(1'b1, 16'h0555, 1'b0);
      step(1'b1, 16'hFF10, 1'b0);
      check_state("bcast");
      check_val("bcast_dpop", 32'(bif.D_pop), 32'hFF10);
      check_val("bcast_drop", 32'(bif.drop_cnt), 32'd1);

      // Fill past depth from a clean start.
      do_reset();
      for (int i = 0; i < 9; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0);
      check_state("fill");
      check_val("fill_count", 32'(bif.count), 32'd8);
      check_val("fill_ovf", 32'(bif.overflow), 32'd1);
      check_val("fill_drop", 32'(bif.drop_cnt), 32'd1);
      check_val("fill_dpop", 32'(bif.D_pop), 32'h0200);

      // Push with pop while full: occupancy unchanged, then drain through the wrap.
      step(1'b1, 16'h02AA, 1'b1);
      check_state("fullpp");
      check_val("fullpp_count", 32'(bif.count), 32'd8);
      check_val("fullpp_dpop", 32'(bif.D_pop), 32'h0201);
      for (int i = 0; i < 7; i++) step(1'b0, '0, 1'b1);
      check_val("wrap_dpop", 32'(bif.D_pop), 32'h02AA);
      step(1'b0, '0, 1'b1);
      check_state("empty");

      // Pop on empty, then hit push with pop on empty.
      step(1'b0, '0, 1'b1);
      check_state("underflow");
      check_val("unf_flag", 32'(bif.underflow), 32'd1);
      step(1'b1, 16'h0277, 1'b1);
      check_state("empty_pp");
      step(1'b0, '0, 1'b1);

      // Random traffic through the scoreboard.
      for (int i = 0; i < 300; i++) begin
         logic [7:0] hdr;
         case ($urandom_range(0, 3))
            0, 1:    hdr = 8'h02;
            2:       hdr = 8'hFF;
            default: hdr = 8'h05;
         endcase
         step(1'($urandom_range(0, 1)), {hdr, 8'($urandom)}, ($urandom_range(0, 2) == 0));
      end
      check_state("random");

      // Asynchronous reset with four entries stored.
      while (sb_q.size() != 0) step(1'b0, '0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 16'h0230 + 16'(i), 1'b0);
      check_val("pre_rst_count", 32'(bif.count), 32'd4);
      reset = 1'b0;
      model_reset();
      #2;
      check_state("async_rst");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 16'h0299, 1'b0);
      check_state("post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bus_rx_fifo.md
Name: bus_rx_fifo

Overview:
- Receive-side terminal buffer that sits on one output port of the bus generator/arbiter (`bs_gnrtr_n_rbtr`).
- Accepts packets the bus delivers through push/D_push and checks the destination field.
- Stores accepted packets in a show-ahead FIFO and presents them to the local consumer (monitor or device) through pndng/pop/D_pop, the same handshake the bus uses on its input side.
- Tracks drops and errors for the scoreboard.

Parameters:
- pckg_sz, 16, packet width in bits; destination id is D_push[pckg_sz-1 -: 8]; must be >= 9.
- depth, 8, FIFO entries; power of two, >= 2.
- id, 0, this terminal's 8-bit destination id.
- broadcast, 8'hFF, destination value accepted by every terminal.
- cnt_w, 16, width of the statistics counters.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-low reset.
- push, input, 1, bus strobes D_push valid for one cycle.
- D_push, input, pckg_sz, packet from bus.
- pop, input, 1, consumer takes the head entry.
- D_pop, output, pckg_sz, head entry (show-ahead); 0 when empty.
- pndng, output, 1, FIFO non-empty.
- full, output, 1, count == depth.
- count, output, $clog2(depth)+1, occupancy.
- overflow, output, 1, sticky; a push was dropped because the FIFO was full.
- underflow, output, 1, sticky; pop was asserted while empty.
- rx_cnt, output, cnt_w, accepted packets, saturating.
- drop_cnt, output, cnt_w, dropped packets (misaddressed or overflow), saturating.

Behaviour:
Reset:
- reset low: immediately clears wr_ptr, rd_ptr, count, overflow, underflow, rx_cnt and drop_cnt.
- Outputs then read pndng=0, full=0, D_pop=0, count=0.
- Memory contents are don't-care.
- Reset asserted mid-operation discards all stored packets. The first push after reset release is accepted normally.

Address match:
- hit = (D_push[pckg_sz-1 -: 8] == id) || (D_push[pckg_sz-1 -: 8] == broadcast).
- The full packet, including the header, is stored unmodified.

Write (push=1 at edge N):
- hit and not full: write mem[wr_ptr], increment wr_ptr (wraps depth-1 -> 0), rx_cnt++.
- hit and full and pop=0: packet dropped, overflow<=1, drop_cnt++.
- hit and full and pop=1: the pop frees a slot in the same edge; the write is accepted and count stays depth.
- miss: dropped, drop_cnt++. overflow and count are unaffected.

Read (pop=1 at edge N):
- Not empty: rd_ptr increments (wraps); D_pop shows the next entry after edge N.
- Empty: no pointer change, underflow<=1.
- Simultaneous hit push and pop with the FIFO empty: the push is accepted, the pop is treated as underflow, and count becomes 1.

Count and outputs:
- count next = count + wr_accept - rd_accept.
- pndng = (count != 0); full = (count == depth). Both are combinational from registered count.

Latency:
- A packet pushed at edge N is visible on D_pop with pndng=1 immediately after edge N (1-cycle write-to-read).
- No combinational path from push or D_push to any output.

Counters:
- Saturate at 2^cnt_w-1 with no wrap.
- rx_cnt and drop_cnt may both be evaluated on the same edge; only one of them changes per push.

Test Plan:
- Reset then idle (id=2): pndng=0, count=0, D_pop=0, all flags and counters 0.
- Push 16'h0201, 16'h0202, 16'h0203 on consecutive cycles, no pop -> count=3. Then 3 pops -> D_pop sequence 0201, 0202, 0203, pndng=0, rx_cnt=3.
- Push 16'h0555 (id 5) and 16'hFF10 (broadcast) -> first dropped (drop_cnt=1), second stored, D_pop=16'hFF10, overflow=0.
- Push 9 hit packets 16'h0200..16'h0208 with no pop -> full=1 after the 8th, 9th dropped. Result: overflow=1, drop_cnt=1, count=8, D_pop=16'h0200.
- With full=1, push 16'h02AA together with pop -> count stays 8, D_pop=16'h0201. After 7 more pops, D_pop=16'h02AA; wr_ptr/rd_ptr wrap is exercised.
- Pop while empty -> underflow=1, count=0. Assert reset low mid-stream with count=4 -> count=0, pndng=0, flags cleared asynchronously before the next clk edge.
